// File: rtl/mdu_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op encodings,
// FSM state encodings and the default post-reset settle length.
package mdu_pkg;

    localparam int MDU_SETTLE_DEFAULT = 68;
    localparam int MDU_DIV_BITS       = 32;

    localparam logic [2:0] MDU_OP_NONE  = 3'd0;
    localparam logic [2:0] MDU_OP_MULT  = 3'd1;
    localparam logic [2:0] MDU_OP_MULTU = 3'd2;
    localparam logic [2:0] MDU_OP_DIV   = 3'd3;
    localparam logic [2:0] MDU_OP_DIVU  = 3'd4;
    localparam logic [2:0] MDU_OP_MTHI  = 3'd5;
    localparam logic [2:0] MDU_OP_MTLO  = 3'd6;
    localparam logic [2:0] MDU_OP_RSVD  = 3'd7;

    typedef enum logic [2:0] {
        ST_SETTLE,
        ST_IDLE,
        ST_MUL,
        ST_DIV_START,
        ST_DIV_WAIT,
        ST_DIV_DRAIN
    } mdu_state_e;

    typedef enum logic [1:0] {
        DV_IDLE,
        DV_SHIFT,
        DV_SUB,
        DV_FIN
    } div_state_e;

endpackage

// File: rtl/hilo_muldiv_divider.sv
// Iterative restoring divider (module divider). Samples start in idle,
// then spends two cycles per quotient bit (shift, subtract) and asserts
// done for one cycle in the finish state. Has no reset: the owner must
// let an interrupted divide run to completion and ignore its done.
module divider
    import mdu_pkg::*;
(
    input  logic        clk,
    input  logic        start,
    input  logic        signed_div,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        done,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);

    div_state_e  state_q, state_d;
    logic [32:0] rem_q, rem_d;
    logic [31:0] quo_q, quo_d;
    logic [31:0] dsr_q, dsr_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        neg_quo_q, neg_quo_d;
    logic        neg_rem_q, neg_rem_d;

    // Datapath registers; no reset on purpose.
    always_ff @(posedge clk) begin
        state_q   <= state_d;
        rem_q     <= rem_d;
        quo_q     <= quo_d;
        dsr_q     <= dsr_d;
        cnt_q     <= cnt_d;
        neg_quo_q <= neg_quo_d;
        neg_rem_q <= neg_rem_d;
    end

    // Next-state logic: magnitude division, signs applied on output.
    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dsr_d     = dsr_q;
        cnt_d     = cnt_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        case (state_q)
            DV_IDLE: begin
                if (start) begin
                    quo_d     = (signed_div && dividend[31]) ? -dividend : dividend;
                    dsr_d     = (signed_div && divisor[31])  ? -divisor  : divisor;
                    rem_d     = '0;
                    cnt_d     = '0;
                    neg_quo_d = signed_div && (dividend[31] ^ divisor[31]);
                    neg_rem_d = signed_div && dividend[31];
                    state_d   = DV_SHIFT;
                end
            end
            DV_SHIFT: begin
                rem_d   = {rem_q[31:0], quo_q[31]};
                quo_d   = {quo_q[30:0], 1'b0};
                state_d = DV_SUB;
            end
            DV_SUB: begin
                if (rem_q >= {1'b0, dsr_q}) begin
                    rem_d    = rem_q - {1'b0, dsr_q};
                    quo_d[0] = 1'b1;
                end
                if (cnt_q == 5'(MDU_DIV_BITS - 1)) begin
                    state_d = DV_FIN;
                end else begin
                    cnt_d   = cnt_q + 5'd1;
                    state_d = DV_SHIFT;
                end
            end
            DV_FIN: begin
                state_d = DV_IDLE;
            end
            default: begin
                state_d = DV_IDLE;
            end
        endcase
    end

    assign done      = (state_q == DV_FIN);
    assign quotient  = neg_quo_q ? -quo_q : quo_q;
    assign remainder = neg_rem_q ? -rem_q[31:0] : rem_q[31:0];

endmodule

// File: rtl/hilo_muldiv.sv
// HI/LO register file plus multiply/divide sequencing for the EX stage.
// Optional feature macro: HILO_FWD_EN (forward MTHI/MTLO being accepted
// combinationally onto hi/lo).
module hilo_muldiv
    import mdu_pkg::*;
#(
    parameter int SETTLE_CYCLES = MDU_SETTLE_DEFAULT
)
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        op_valid,
    input  logic [2:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        flush,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int CNT_W = $clog2(SETTLE_CYCLES) + 1;

    mdu_state_e       state_q, state_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;
    logic [31:0]      opa_q, opa_d;
    logic [31:0]      opb_q, opb_d;
    logic             sgn_q, sgn_d;
    logic [CNT_W-1:0] settle_cnt_q, settle_cnt_d;

    logic        accept;
    logic        div_start;
    logic        div_done;
    logic [31:0] div_quo;
    logic [31:0] div_rem;
    logic [63:0] mul_a, mul_b, mul_prod;

    // Low 64 bits of the 33x33 product equal a 64x64 product of the
    // operands extended (sign or zero) to 64 bits.
    assign mul_a    = {{32{sgn_q & opa_q[31]}}, opa_q};
    assign mul_b    = {{32{sgn_q & opb_q[31]}}, opb_q};
    assign mul_prod = mul_a * mul_b;

    assign accept    = op_valid && !flush;
    assign busy      = (state_q != ST_IDLE);
    assign div_start = (state_q == ST_DIV_START);

    divider u_divider (
        .clk        (clk),
        .start      (div_start),
        .signed_div (sgn_q),
        .dividend   (opa_q),
        .divisor    (opb_q),
        .done       (div_done),
        .quotient   (div_quo),
        .remainder  (div_rem)
    );

    // State, architectural HI/LO and operand latches.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= ST_SETTLE;
            hi_q         <= '0;
            lo_q         <= '0;
            opa_q        <= '0;
            opb_q        <= '0;
            sgn_q        <= 1'b0;
            settle_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            hi_q         <= hi_d;
            lo_q         <= lo_d;
            opa_q        <= opa_d;
            opb_q        <= opb_d;
            sgn_q        <= sgn_d;
            settle_cnt_q <= settle_cnt_d;
        end
    end

    // Sequencing: accept ops in IDLE, commit results unless flushed.
    always_comb begin
        state_d      = state_q;
        hi_d         = hi_q;
        lo_d         = lo_q;
        opa_d        = opa_q;
        opb_d        = opb_q;
        sgn_d        = sgn_q;
        settle_cnt_d = settle_cnt_q;
        case (state_q)
            ST_SETTLE: begin
                settle_cnt_d = settle_cnt_q + 1'b1;
                if (settle_cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (accept) begin
                    case (op)
                        MDU_OP_MTHI: hi_d = rs_val;
                        MDU_OP_MTLO: lo_d = rs_val;
                        MDU_OP_MULT, MDU_OP_MULTU: begin
                            opa_d   = rs_val;
                            opb_d   = rt_val;
                            sgn_d   = (op == MDU_OP_MULT);
                            state_d = ST_MUL;
                        end
                        MDU_OP_DIV, MDU_OP_DIVU: begin
                            opa_d   = rs_val;
                            opb_d   = rt_val;
                            sgn_d   = (op == MDU_OP_DIV);
                            state_d = ST_DIV_START;
                        end
                        default: ;
                    endcase
                end
            end
            ST_MUL: begin
                if (!flush) begin
                    {hi_d, lo_d} = mul_prod;
                end
                state_d = ST_IDLE;
            end
            ST_DIV_START: begin
                state_d = flush ? ST_DIV_DRAIN : ST_DIV_WAIT;
            end
            ST_DIV_WAIT: begin
                if (div_done) begin
                    if (!flush) begin
                        hi_d = div_rem;
                        lo_d = div_quo;
                    end
                    state_d = ST_IDLE;
                end else if (flush) begin
                    state_d = ST_DIV_DRAIN;
                end
            end
            ST_DIV_DRAIN: begin
                if (div_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_SETTLE;
            end
        endcase
    end

`ifdef HILO_FWD_EN
    logic fwd_ok;
    assign fwd_ok = (state_q == ST_IDLE) && accept;
    assign hi = (fwd_ok && op == MDU_OP_MTHI) ? rs_val : hi_q;
    assign lo = (fwd_ok && op == MDU_OP_MTLO) ? rs_val : lo_q;
`else
    assign hi = hi_q;
    assign lo = lo_q;
`endif

endmodule

// File: tb/tb_hilo_muldiv.sv
// Self-checking bench for hilo_muldiv: directed table, hand-written
// flush/reset/forwarding sequences and a randomized run against a
// plain-arithmetic HI/LO model.
module tb_hilo_muldiv;
    import mdu_pkg::*;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        op_valid = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] rs_val = '0;
    logic [31:0] rt_val = '0;
    logic        flush = 1'b0;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int tests = 0;
    int fails = 0;

    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
        bit          chk;
    } vec_t;

    vec_t vt[11];

    hilo_muldiv #(.SETTLE_CYCLES(68)) dut (
        .clk      (clk),
        .resetn   (resetn),
        .op_valid (op_valid),
        .op       (op),
        .rs_val   (rs_val),
        .rt_val   (rt_val),
        .flush    (flush),
        .busy     (busy),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Counts cycles with busy high from the current cycle, bounded.
    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 200) begin
            step();
            n++;
        end
        if (busy) begin
            tests++;
            fails++;
            $display("FAIL timeout: busy=%0b after %0d cycles, required 0", busy, n);
        end
    endtask

    // Presents one op for one cycle; returns in cycle 1.
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        int n;
        wait_idle(n);
        op_valid = 1'b1;
        op       = o;
        rs_val   = a;
        rt_val   = b;
        step();
        op_valid = 1'b0;
        op       = MDU_OP_NONE;
    endtask

    function automatic int exp_cycles(input logic [2:0] o);
        case (o)
            MDU_OP_MULT, MDU_OP_MULTU: return 1;
            MDU_OP_DIV, MDU_OP_DIVU:   return 66;
            default:                   return 0;
        endcase
    endfunction

    // Architectural effect of one op on the model HI/LO.
    function automatic void model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        logic [63:0]        p;
        case (o)
            MDU_OP_MULT: begin
                sa = $signed(a);
                sb = $signed(b);
                p  = sa * sb;
                {m_hi, m_lo} = p;
            end
            MDU_OP_MULTU: begin
                p = {32'b0, a} * {32'b0, b};
                {m_hi, m_lo} = p;
            end
            MDU_OP_DIV: begin
                m_lo = $signed(a) / $signed(b);
                m_hi = $signed(a) % $signed(b);
            end
            MDU_OP_DIVU: begin
                m_lo = a / b;
                m_hi = a % b;
            end
            MDU_OP_MTHI: m_hi = a;
            MDU_OP_MTLO: m_lo = a;
            default: ;
        endcase
    endfunction

    initial begin
        int n;
        logic [2:0]  o;
        logic [31:0] a;
        logic [31:0] b;

        vt[0]  = '{MDU_OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 66, 1'b1};
        vt[1]  = '{MDU_OP_DIVU,  32'd5,        32'd0,        32'h0,        32'h0,        66, 1'b0};
        vt[2]  = '{MDU_OP_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       66, 1'b1};
        vt[3]  = '{MDU_OP_MULT,  32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFE, 1,  1'b1};
        vt[4]  = '{MDU_OP_MULTU, 32'hFFFFFFFF, 32'd2,        32'h1,        32'hFFFFFFFE, 1,  1'b1};
        vt[5]  = '{MDU_OP_MTHI,  32'hCAFEF00D, 32'd9,        32'hCAFEF00D, 32'hFFFFFFFE, 0,  1'b1};
        vt[6]  = '{MDU_OP_MTLO,  32'h1234,     32'd9,        32'hCAFEF00D, 32'h1234,     0,  1'b1};
        vt[7]  = '{MDU_OP_NONE,  32'd5,        32'd5,        32'hCAFEF00D, 32'h1234,     0,  1'b1};
        vt[8]  = '{MDU_OP_RSVD,  32'd6,        32'd6,        32'hCAFEF00D, 32'h1234,     0,  1'b1};
        vt[9]  = '{MDU_OP_DIV,   32'd7,        32'hFFFFFFFE, 32'h1,        32'hFFFFFFFD, 66, 1'b1};
        vt[10] = '{MDU_OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h0,        1,  1'b1};

        // Reset state and settle length.
        step();
        step();
        check("reset_hi", hi, 0);
        check("reset_lo", lo, 0);
        check("reset_busy", busy, 1);
        resetn = 1'b1;
        wait_idle(n);
        check("settle_cycles", n, 68);

        // Directed table.
        foreach (vt[i]) begin
            issue(vt[i].op, vt[i].rs, vt[i].rt);
            wait_idle(n);
            check($sformatf("vec%0d_busy_cycles", i), n, vt[i].cyc);
            if (vt[i].chk) begin
                check($sformatf("vec%0d_hi", i), hi, vt[i].hi);
                check($sformatf("vec%0d_lo", i), lo, vt[i].lo);
            end
        end
        m_hi = 32'h40000000;
        m_lo = 32'h0;

        // Forwarding of MTHI in the accept cycle.
        wait_idle(n);
        op_valid = 1'b1;
        op       = MDU_OP_MTHI;
        rs_val   = 32'hCAFEF00D;
        #1;
`ifdef HILO_FWD_EN
        check("fwd_hi_cycle0", hi, 32'hCAFEF00D);
`else
        check("fwd_hi_cycle0", hi, m_hi);
`endif
        check("fwd_lo_cycle0", lo, m_lo);
        step();
        op_valid = 1'b0;
        op       = MDU_OP_NONE;
        m_hi     = 32'hCAFEF00D;
        check("fwd_hi_cycle1", hi, m_hi);

        // Flush during MUL leaves HI/LO unchanged.
        issue(MDU_OP_MULT, 32'd3, 32'd3);
        check("mulflush_busy1", busy, 1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("mulflush_busy2", busy, 0);
        check("mulflush_hi", hi, m_hi);
        check("mulflush_lo", lo, m_lo);

        // Flush mid-divide: drain until done, no commit.
        issue(MDU_OP_MTLO, 32'h1234, 32'd0);
        m_lo = 32'h1234;
        issue(MDU_OP_DIVU, 32'd100, 32'd7);
        repeat (9) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        wait_idle(n);
        check("divflush_busy_cycles", n + 10, 66);
        check("divflush_hi", hi, m_hi);
        check("divflush_lo", lo, 32'h1234);
        issue(MDU_OP_DIVU, 32'd9, 32'd4);
        wait_idle(n);
        check("after_flush_hi", hi, 1);
        check("after_flush_lo", lo, 2);

        // Flush in the start cycle.
        issue(MDU_OP_DIVU, 32'd100, 32'd7);
        flush = 1'b1;
        step();
        flush = 1'b0;
        wait_idle(n);
        check("startflush_busy_cycles", n + 1, 66);
        check("startflush_hi", hi, 1);
        check("startflush_lo", lo, 2);

        // Op presented while busy is ignored.
        issue(MDU_OP_DIV, 32'd100, 32'd7);
        repeat (4) step();
        op_valid = 1'b1;
        op       = MDU_OP_MTHI;
        rs_val   = 32'hDEADBEEF;
        step();
        op_valid = 1'b0;
        op       = MDU_OP_NONE;
        wait_idle(n);
        check("busyop_hi", hi, 2);
        check("busyop_lo", lo, 14);

        // Reset in the middle of a divide.
        issue(MDU_OP_DIV, 32'hFFFFFFF9, 32'd2);
        repeat (19) step();
        resetn = 1'b0;
        #1;
        check("midreset_hi", hi, 0);
        check("midreset_lo", lo, 0);
        check("midreset_busy", busy, 1);
        step();
        resetn = 1'b1;
        wait_idle(n);
        check("midreset_settle", n, 68);
        check("midreset_hi_after", hi, 0);
        check("midreset_lo_after", lo, 0);
        issue(MDU_OP_DIVU, 32'd100, 32'd7);
        wait_idle(n);
        check("postreset_busy_cycles", n, 66);
        check("postreset_hi", hi, 2);
        check("postreset_lo", lo, 14);
        m_hi = 32'd2;
        m_lo = 32'd14;

        // Randomized ops against the model.
        for (int k = 0; k < 40; k++) begin
            o = 3'($urandom_range(1, 6));
            a = $urandom;
            b = $urandom;
            if (k % 4 == 0) begin
                a = 32'($urandom_range(0, 300)) - 32'd150;
                b = 32'($urandom_range(0, 20)) - 32'd10;
            end
            if (o == MDU_OP_DIV || o == MDU_OP_DIVU) begin
                if (b == 32'd0) b = 32'd3;
                if (o == MDU_OP_DIV && a == 32'h80000000 && b == 32'hFFFFFFFF) b = 32'd5;
            end
            issue(o, a, b);
            wait_idle(n);
            model(o, a, b);
            check($sformatf("rnd%0d_op%0d_cycles", k, o), n, exp_cycles(o));
            check($sformatf("rnd%0d_op%0d_hi", k, o), hi, m_hi);
            check($sformatf("rnd%0d_op%0d_lo", k, o), lo, m_lo);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/hilo_muldiv.md
# hilo_muldiv

- Multiply/divide unit and HI/LO register file of the MIPS core's EX stage.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from EX and holds the architectural HI/LO registers.
- Runs divides on an internal FSM divider and drives `busy` so the pipeline stalls HI/LO-dependent instructions until results are committed.
- Safe against flushes and resets that occur while a divide is in flight.

## Interface
Parameters:
- `SETTLE_CYCLES`, 68: post-reset drain length. Must be at least the divider's worst-case time to return to its idle state.

Ports:
- `clk`  in  1: clock, rising edge.
- `resetn`  in  1: asynchronous, active-low reset.
- `op_valid`  in  1: EX presents an op this cycle.
- `op`  in  3: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as NONE).
- `rs_val`  in  32: dividend / multiplicand / MTHI-MTLO source.
- `rt_val`  in  32: divisor / multiplier.
- `flush`  in  1: kill the current and in-flight op.
- `busy`  out  1: unit cannot accept an op; HI/LO not final.
- `hi`  out  32: HI register value.
- `lo`  out  32: LO register value.

## Operation
States: SETTLE, IDLE, MUL, DIV_START, DIV_WAIT, DIV_DRAIN.

- **Reset:** `hi`=0, `lo`=0, state=SETTLE, settle counter=0, operand latches=0.
- **SETTLE:** `busy`=1. Counter increments every cycle; at `SETTLE_CYCLES-1` the state moves to IDLE. `op_valid` is ignored.
  - Purpose: the divider has no reset, so a divide interrupted by reset must finish and its `done` must be discarded.
- **IDLE:** `busy`=0. An op is accepted when `op_valid && !flush`.
  - MTHI/MTLO: write `rs_val` into HI/LO at the accepting edge. State stays IDLE.
  - MULT/MULTU: latch `rs_val`, `rt_val` and the signed flag, then go to MUL.
  - DIV/DIVU: latch the same operands and flag, then go to DIV_START.
  - NONE/7: no effect.
- **MUL:** `busy`=1.
  - Signed: product = sign-extend both operands to 33 bits, multiply, keep the low 64 bits.
  - Unsigned: product = zero-extend both operands to 33 bits, multiply, keep the low 64 bits.
  - Write {HI,LO} = product and go to IDLE, unless `flush`, in which case go to IDLE and leave HI/LO unchanged.
- **DIV_START:** `busy`=1. Divider `start`=1 for exactly this cycle. Divider operands come from the latches and stay constant until the divider's `done`.
  - Next state is DIV_DRAIN if `flush`, else DIV_WAIT.
- **DIV_WAIT:** `busy`=1.
  - On divider `done`: if `!flush`, write HI=remainder and LO=quotient; go to IDLE in either case.
  - If `flush` without `done`: go to DIV_DRAIN.
- **DIV_DRAIN:** `busy`=1. Stay until `done`, discard the result, then go to IDLE. `flush` has no effect here.
- **Divider outside divide states:** `done` observed in any state other than DIV_WAIT/DIV_DRAIN is ignored.
- **Divide by zero:** architecturally undefined. The unit commits whatever the divider produces and does not hang.
- **Op while busy:** `op_valid` while `busy`=1 is ignored. Upstream is required to stall and re-present the op.

## Timing
Cycle 0 is the accept cycle.

- **MTHI/MTLO:** new value on `hi`/`lo` in cycle 1. With `HILO_FWD_EN`, also visible in cycle 0.
- **MULT:** `busy` high in cycle 1; HI/LO updated and `busy`=0 in cycle 2.
- **DIV:**
  - `start` high in cycle 1.
  - Divider `done` in cycle 66 (1 start sample + 32×2 subtract/shift + 1 finish).
  - HI/LO written at the end of cycle 66; `busy`=0 and results visible in cycle 67.
  - The FSM must key on `done`, not on a count.
- **Settle:** `busy` high for `SETTLE_CYCLES` cycles after `resetn` deasserts.

## Configuration
- `HILO_FWD_EN` defined: `hi`/`lo` combinationally forward an MTHI/MTLO being accepted in the current cycle. Each register is forwarded independently.
- `HILO_FWD_EN` undefined: `hi`/`lo` are pure register outputs; MTHI/MTLO become visible one cycle after accept.

## Structure
- **Shared package `mdu_pkg`:** op encoding constants (`MDU_OP_*`), state encoding, and the default settle length.
- **Sub-module:** instantiate the team's existing FSM divider (`divider`) as `u_divider`. Its `signed_div`, `dividend` and `divisor` are driven from the latches.
- **Multiply:** inline 33×33 signed multiply; no sub-module.

## Test plan
- **DIV −7/2:** after settle, DIV with rs=0xFFFFFFF9, rt=2 → cycle 67: LO=0xFFFFFFFD, HI=0xFFFFFFFF; `busy` high for cycles 1–66.
- **DIVU 100/7:** rs=100, rt=7 → LO=14, HI=2.
- **MULT vs MULTU:** rs=0xFFFFFFFF, rt=2.
  - MULT → HI=0xFFFFFFFF, LO=0xFFFFFFFE at cycle 2.
  - MULTU → HI=1, LO=0xFFFFFFFE.
- **Flush mid-divide:** MTLO 0x1234, then DIVU 100/7 with `flush` at cycle 10 → LO stays 0x1234, `busy` stays high until cycle 66. A following DIVU 9/4 gives LO=2, HI=1.
- **Reset mid-divide:** `resetn` low at cycle 20 of a DIV → `hi`=`lo`=0 and `busy`=1 for 68 cycles. A following DIVU 100/7 gives LO=14, HI=2, with no stale write.
- **Forwarding:** MTHI 0xCAFEF00D.
  - With `HILO_FWD_EN`: `hi`=0xCAFEF00D in cycle 0.
  - Without it: `hi` shows the old value in cycle 0 and 0xCAFEF00D in cycle 1.
